// File: rtl/program_sequencer_pkg.sv
// Shared widths, opcodes, instruction field positions and state encoding for the program sequencer.
package program_sequencer_pkg;

    localparam int unsigned PC_WIDTH    = 4;
    localparam int unsigned INSTR_WIDTH = 9;
    localparam int unsigned CNT_WIDTH   = 8;
    localparam int unsigned OP_WIDTH    = 3;
    localparam int unsigned RADDR_WIDTH = 2;
    localparam int unsigned IMM_WIDTH   = 4;

    // Instruction field positions: [8:6] opcode, [5:4] rd, [3:2] ra, [1:0] rb, [3:0] imm
    localparam int unsigned OP_LSB  = 6;
    localparam int unsigned RD_LSB  = 4;
    localparam int unsigned RA_LSB  = 2;
    localparam int unsigned RB_LSB  = 0;
    localparam int unsigned IMM_LSB = 0;

    localparam logic [OP_WIDTH-1:0] OP_ADD  = 3'b000;
    localparam logic [OP_WIDTH-1:0] OP_SUB  = 3'b001;
    localparam logic [OP_WIDTH-1:0] OP_AND  = 3'b010;
    localparam logic [OP_WIDTH-1:0] OP_OR   = 3'b011;
    localparam logic [OP_WIDTH-1:0] OP_XOR  = 3'b100;
    localparam logic [OP_WIDTH-1:0] OP_LI   = 3'b101;
    localparam logic [OP_WIDTH-1:0] OP_JMP  = 3'b110;
    localparam logic [OP_WIDTH-1:0] OP_HALT = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_HALTED    = 3'd5
    } state_e;

    // Control bundle produced by the instruction decoder
    typedef struct packed {
        logic [OP_WIDTH-1:0] alu_op;
        logic                rf_we_class;
        logic                rf_wsel;
        logic                is_jmp;
        logic                is_halt;
    } dec_t;

endpackage

// File: rtl/program_sequencer_instr_decoder.sv
// Combinational opcode decode into ALU operation and write/branch control.
module program_sequencer_instr_decoder
    import program_sequencer_pkg::*;
(
    input  logic [OP_WIDTH-1:0] opcode,
    output dec_t                dec_c
);

    // ALU-class opcodes pass through as the ALU operation; others write nothing to the ALU
    always_comb begin
        dec_c             = '0;
        dec_c.rf_wsel     = (opcode == OP_LI);
        dec_c.is_jmp      = (opcode == OP_JMP);
        dec_c.is_halt     = (opcode == OP_HALT);
        dec_c.rf_we_class = (opcode <= OP_XOR) || (opcode == OP_LI);
        if (opcode <= OP_XOR) begin
            dec_c.alu_op = opcode;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Four-cycle fetch/decode/execute/writeback controller driving the instruction memory and register file.
module program_sequencer
    import program_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [INSTR_WIDTH-1:0] instr_in,
    output logic [PC_WIDTH-1:0]    pc_out,
    output logic [RADDR_WIDTH-1:0] rf_addr_a,
    output logic [RADDR_WIDTH-1:0] rf_addr_b,
    output logic [RADDR_WIDTH-1:0] rf_waddr,
    output logic                   rf_we,
    output logic                   rf_wsel,
    output logic [IMM_WIDTH-1:0]   imm_out,
    output logic [OP_WIDTH-1:0]    alu_op,
    output logic                   busy,
    output logic                   halted,
    output logic [CNT_WIDTH-1:0]   retired
);

    state_e                 state_q, state_d;
    logic [PC_WIDTH-1:0]    pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_WIDTH-1:0]   retired_q, retired_d;
    logic                   rf_we_q, rf_we_d;
    logic                   rf_wsel_q, rf_wsel_d;
    logic [OP_WIDTH-1:0]    alu_op_q, alu_op_d;
    logic                   busy_q, busy_d;
    logic                   halted_q, halted_d;
    dec_t                   dec_c;

    // IR captures the memory word in DECODE and holds otherwise; decode sees the value IR will hold
    always_comb begin
        ir_d = ir_q;
        if (state_q == ST_DECODE) begin
            ir_d = instr_in;
        end
    end

    program_sequencer_instr_decoder u_instr_decoder (
        .opcode (ir_d[OP_LSB +: OP_WIDTH]),
        .dec_c  (dec_c)
    );

    // Next-state, PC, retire counter and registered control outputs
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        alu_op_d  = dec_c.alu_op;
        rf_wsel_d = dec_c.rf_wsel;
        unique case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            ST_FETCH:   state_d = ST_DECODE;
            ST_DECODE:  state_d = dec_c.is_halt ? ST_HALTED : ST_EXECUTE;
            ST_EXECUTE: state_d = ST_WRITEBACK;
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
                pc_d    = dec_c.is_jmp ? PC_WIDTH'(ir_q[IMM_LSB +: IMM_WIDTH])
                                       : PC_WIDTH'(pc_q + 1'b1);
                if (retired_q != '1) begin
                    retired_d = CNT_WIDTH'(retired_q + 1'b1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rf_we_d  = (state_d == ST_WRITEBACK) && dec_c.rf_we_class;
        busy_d   = (state_d == ST_FETCH) || (state_d == ST_DECODE) ||
                   (state_d == ST_EXECUTE) || (state_d == ST_WRITEBACK);
        halted_d = (state_d == ST_HALTED);
    end

    // State and output registers; reset abandons any instruction in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pc_q      <= '0;
            ir_q      <= '0;
            retired_q <= '0;
            rf_we_q   <= 1'b0;
            rf_wsel_q <= 1'b0;
            alu_op_q  <= '0;
            busy_q    <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
            rf_we_q   <= rf_we_d;
            rf_wsel_q <= rf_wsel_d;
            alu_op_q  <= alu_op_d;
            busy_q    <= busy_d;
            halted_q  <= halted_d;
        end
    end

    assign pc_out    = pc_q;
    assign rf_addr_a = ir_q[RA_LSB +: RADDR_WIDTH];
    assign rf_addr_b = ir_q[RB_LSB +: RADDR_WIDTH];
    assign rf_waddr  = ir_q[RD_LSB +: RADDR_WIDTH];
    assign imm_out   = ir_q[IMM_LSB +: IMM_WIDTH];
    assign rf_we     = rf_we_q;
    assign rf_wsel   = rf_wsel_q;
    assign alu_op    = alu_op_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench: instruction memory and register-file model around the program sequencer.
module tb_program_sequencer;
    import program_sequencer_pkg::*;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   start;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic [PC_WIDTH-1:0]    pc_out;
    logic [1:0]             rf_addr_a, rf_addr_b, rf_waddr;
    logic                   rf_we, rf_wsel, busy, halted;
    logic [3:0]             imm_out;
    logic [2:0]             alu_op;
    logic [7:0]             retired;

    logic [8:0] mem [16];
    logic [7:0] rf  [4];
    logic [16:0] we_seen;
    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    program_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .instr_in  (instr_in),
        .pc_out    (pc_out),
        .rf_addr_a (rf_addr_a),
        .rf_addr_b (rf_addr_b),
        .rf_waddr  (rf_waddr),
        .rf_we     (rf_we),
        .rf_wsel   (rf_wsel),
        .imm_out   (imm_out),
        .alu_op    (alu_op),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    assign instr_in = mem[pc_out];

    function automatic logic [7:0] alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return 8'd0;
        endcase
    endfunction

    // Register-file model written on the WRITEBACK edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) rf[i] <= 8'd0;
        end else if (rf_we) begin
            rf[rf_waddr] <= rf_wsel ? {4'd0, imm_out} : alu(alu_op, rf[rf_addr_a], rf[rf_addr_b]);
        end
    end

    function automatic logic [8:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb};
    endfunction

    function automatic logic [8:0] mk_imm(input logic [2:0] op, input logic [1:0] rd, input logic [3:0] imm);
        return {op, rd, imm};
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-cycle start pulse; returns at the first negedge after the sampling edge
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < 16; i++) mem[i] = mk(OP_HALT, 2'd0, 2'd0, 2'd0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fill_halt();
        cycles(2);
        check_eq("rst_pc", int'(pc_out), 0);
        check_eq("rst_we", int'(rf_we), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_halted", int'(halted), 0);
        check_eq("rst_retired", int'(retired), 0);
        reset = 1'b0;
        cycles(1);

        // start together with reset: reset wins
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        cycles(1);
        check_eq("rst_start_busy", int'(busy), 0);

        // T1: reset during WRITEBACK of LI
        mem[0] = mk_imm(OP_LI, 2'd3, 4'd5);
        pulse_start();
        cycles(3);
        check_eq("t1_we_in_wb", int'(rf_we), 1);
        #1 reset = 1'b1;
        #1;
        check_eq("t1_we_drop", int'(rf_we), 0);
        check_eq("t1_pc", int'(pc_out), 0);
        check_eq("t1_busy", int'(busy), 0);
        check_eq("t1_retired", int'(retired), 0);
        @(negedge clk);
        reset = 1'b0;
        cycles(2);
        check_eq("t1_r3", int'(rf[3]), 0);
        check_eq("t1_idle", int'(busy), 0);

        // T2: LI r0,3 / LI r1,6 / ADD r2,r0,r1 / HALT
        fill_halt();
        mem[0] = mk_imm(OP_LI, 2'd0, 4'd3);
        mem[1] = mk_imm(OP_LI, 2'd1, 4'd6);
        mem[2] = mk(OP_ADD, 2'd2, 2'd0, 2'd1);
        we_seen = '0;
        pulse_start();
        we_seen[1] = rf_we;
        for (int k = 2; k <= 15; k++) begin
            @(negedge clk);
            we_seen[k] = rf_we;
        end
        check_eq("t2_we_pattern", int'(we_seen), 'h1110);
        check_eq("t2_halted", int'(halted), 1);
        check_eq("t2_busy", int'(busy), 0);
        check_eq("t2_retired", int'(retired), 3);
        check_eq("t2_pc", int'(pc_out), 3);
        check_eq("t2_r0", int'(rf[0]), 3);
        check_eq("t2_r1", int'(rf[1]), 6);
        check_eq("t2_r2", int'(rf[2]), 9);

        // T3: JMP 2 at address 0 skips the LI at address 1
        fill_halt();
        mem[0] = mk_imm(OP_JMP, 2'd0, 4'd2);
        mem[1] = mk_imm(OP_LI, 2'd1, 4'd15);
        we_seen = '0;
        pulse_start();
        we_seen[1] = rf_we;
        for (int k = 2; k <= 7; k++) begin
            @(negedge clk);
            we_seen[k] = rf_we;
            if (k == 5) begin
                check_eq("t3_pc_target", int'(pc_out), 2);
                check_eq("t3_retired", int'(retired), 1);
            end
        end
        check_eq("t3_no_we", int'(we_seen), 0);
        check_eq("t3_halted", int'(halted), 1);
        check_eq("t3_pc_halt", int'(pc_out), 2);
        check_eq("t3_r1", int'(rf[1]), 6);

        // T4: sixteen non-jump instructions, PC wraps 15 -> 0
        for (int i = 0; i < 15; i++) mem[i] = mk_imm(OP_LI, 2'd0, 4'(i));
        mem[15] = mk_imm(OP_LI, 2'd1, 4'd10);
        pulse_start();
        cycles(59);
        mem[0] = mk(OP_HALT, 2'd0, 2'd0, 2'd0);
        cycles(1);
        check_eq("t4_pc15", int'(pc_out), 15);
        cycles(4);
        check_eq("t4_pc_wrap", int'(pc_out), 0);
        check_eq("t4_retired", int'(retired), 16);
        cycles(2);
        check_eq("t4_halted", int'(halted), 1);
        check_eq("t4_r0", int'(rf[0]), 14);
        check_eq("t4_r1", int'(rf[1]), 10);

        // T5: start while busy ignored; start in HALTED restarts
        fill_halt();
        mem[0] = mk_imm(OP_LI, 2'd0, 4'd1);
        mem[1] = mk(OP_XOR, 2'd2, 2'd0, 2'd1);
        pulse_start();
        cycles(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("t5_busy_pc", int'(pc_out), 1);
        check_eq("t5_busy_retired", int'(retired), 1);
        check_eq("t5_busy", int'(busy), 1);
        check_eq("t5_alu_op", int'(alu_op), 4);
        cycles(4);
        check_eq("t5_halted", int'(halted), 1);
        check_eq("t5_retired", int'(retired), 2);
        check_eq("t5_r2", int'(rf[2]), 11);
        pulse_start();
        check_eq("t5_restart_pc", int'(pc_out), 0);
        check_eq("t5_restart_retired", int'(retired), 0);
        check_eq("t5_restart_busy", int'(busy), 1);
        check_eq("t5_restart_halted", int'(halted), 0);

        // T6: JMP-to-self for 300 instructions, counter saturates
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        cycles(1);
        mem[0] = mk_imm(OP_JMP, 2'd0, 4'd0);
        pulse_start();
        cycles(400);
        check_eq("t6_retired_100", int'(retired), 100);
        check_eq("t6_pc", int'(pc_out), 0);
        cycles(800);
        check_eq("t6_retired_sat", int'(retired), 255);
        check_eq("t6_busy", int'(busy), 1);
        check_eq("t6_not_halted", int'(halted), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
